// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer:
// FSM states, opcodes and the datapath control-bus field encodings.
package multicycle_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_SLT   = 4'd4;
   localparam logic [3:0] ALU_FUNCT = 4'd15;

   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   localparam logic [1:0] DST_RT  = 2'd0;
   localparam logic [1:0] DST_RD  = 2'd1;
   localparam logic [1:0] DST_R31 = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam logic [1:0] FMT_R = 2'd0;
   localparam logic [1:0] FMT_I = 2'd1;
   localparam logic [1:0] FMT_J = 2'd2;

   function automatic logic is_legal(input logic [5:0] op);
      case (op)
         OP_R, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL: is_legal = 1'b1;
         default:                                                  is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_wait_watchdog.sv
// Counts consecutive memory-wait cycles and flags when the count sits at
// WAIT_LIMIT; a WAIT_LIMIT of 0 disables the flag entirely.
module mc_wait_watchdog #(
   parameter int WAIT_LIMIT = 255,
   parameter int CNT_W      = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   logic [CNT_W-1:0] cnt;

   // Saturates so a disabled watchdog never wraps back to a small value.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + CNT_W'(1);
   end

   assign expired = (WAIT_LIMIT != 0) && (cnt == CNT_W'(WAIT_LIMIT));

endmodule

// File: rtl/multicycle_control.sv
// FETCH/DECODE/EXEC/MEM/WB control sequencer with memory-ready stalls and a
// wait watchdog. Optional perf counters: define MULTICYCLE_PERF_CNT_EN.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int WAIT_LIMIT = 255,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op_code,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] PCSrc,
   output logic [1:0] RegDst,
   output logic       RegWrite,
   output logic       ExtSel,
   output logic [3:0] OpSel,
   output logic       BSrc,
   output logic       MemWrite,
   output logic [1:0] WBSrc,
   output logic [1:0] comFormat,
   output logic       halted
`ifdef MULTICYCLE_PERF_CNT_EN
   ,
   output logic [31:0] instr_retired,
   output logic [31:0] stall_cycles
`endif
);

   state_t     state, state_next;
   logic [5:0] op_q;
   logic       waiting;
   logic       wd_expired;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         op_q  <= '0;
      end else begin
         state <= state_next;
         if (state == DECODE)
            op_q <= op_code;
      end
   end

   assign waiting = ((state == FETCH) || (state == MEM)) && !mem_ready;

   mc_wait_watchdog #(
      .WAIT_LIMIT (WAIT_LIMIT),
      .CNT_W      (CNT_W)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_next != state),
      .inc     (waiting),
      .expired (wd_expired)
   );

   // NOTE: every output and state_next gets a default first so no path infers a latch.
   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      PCSrc      = PC_PLUS4;
      RegDst     = DST_RT;
      RegWrite   = 1'b0;
      ExtSel     = 1'b0;
      OpSel      = ALU_ADD;
      BSrc       = 1'b0;
      MemWrite   = 1'b0;
      WBSrc      = WB_ALU;
      comFormat  = FMT_R;
      halted     = 1'b0;

      case (state)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = DECODE;
            end else if (wd_expired) begin
               state_next = HALT;
            end
         end

         DECODE: state_next = is_legal(op_code) ? EXEC : HALT;

         EXEC: begin
            case (op_q)
               OP_R: begin
                  OpSel      = ALU_FUNCT;
                  state_next = WB;
               end
               OP_ADDI: begin
                  comFormat  = FMT_I;
                  BSrc       = 1'b1;
                  ExtSel     = 1'b1;
                  state_next = WB;
               end
               OP_ORI: begin
                  comFormat  = FMT_I;
                  OpSel      = ALU_OR;
                  BSrc       = 1'b1;
                  state_next = WB;
               end
               OP_LW, OP_SW: begin
                  comFormat  = FMT_I;
                  BSrc       = 1'b1;
                  ExtSel     = 1'b1;
                  state_next = MEM;
               end
               OP_BEQ: begin
                  comFormat  = FMT_I;
                  OpSel      = ALU_SUB;
                  ExtSel     = 1'b1;
                  pc_write   = zero;
                  PCSrc      = PC_BRANCH;
                  state_next = FETCH;
               end
               OP_J: begin
                  comFormat  = FMT_J;
                  pc_write   = 1'b1;
                  PCSrc      = PC_JUMP;
                  state_next = FETCH;
               end
               OP_JAL: begin
                  comFormat  = FMT_J;
                  pc_write   = 1'b1;
                  PCSrc      = PC_JUMP;
                  RegWrite   = 1'b1;
                  RegDst     = DST_R31;
                  WBSrc      = WB_PC4;
                  state_next = FETCH;
               end
               default: state_next = HALT;
            endcase
         end

         MEM: begin
            mem_req  = 1'b1;
            MemWrite = (op_q == OP_SW);
            if (mem_ready)
               state_next = (op_q == OP_SW) ? FETCH : WB;
            else if (wd_expired)
               state_next = HALT;
         end

         WB: begin
            RegWrite   = 1'b1;
            RegDst     = (op_q == OP_R) ? DST_RD : DST_RT;
            WBSrc      = (op_q == OP_LW) ? WB_MEM : WB_ALU;
            state_next = FETCH;
         end

         HALT: halted = 1'b1;

         default: state_next = FETCH;
      endcase
   end

`ifdef MULTICYCLE_PERF_CNT_EN
   logic retire_evt;

   assign retire_evt = (state_next == FETCH) &&
                       ((state == EXEC) || (state == MEM) || (state == WB));

   // Retire count wraps naturally; stall count saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_retired <= '0;
         stall_cycles  <= '0;
      end else begin
         if (retire_evt)
            instr_retired <= instr_retired + 32'd1;
         if (waiting && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each stimulus cycle queues the hand-derived
// control-bus word, and a negedge monitor pops and compares it against the DUT.
module tb_multicycle_control;
   import multicycle_pkg::*;

   typedef struct packed {
      logic       mem_req;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic [1:0] reg_dst;
      logic       reg_write;
      logic       ext_sel;
      logic [3:0] op_sel;
      logic       b_src;
      logic       mem_write;
      logic [1:0] wb_src;
      logic [1:0] com_format;
      logic       halted;
   } ctl_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op_code = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, ir_write, pc_write, RegWrite, ExtSel, BSrc, MemWrite, halted;
   logic [1:0] PCSrc, RegDst, WBSrc, comFormat;
   logic [3:0] OpSel;
`ifdef MULTICYCLE_PERF_CNT_EN
   logic [31:0] instr_retired, stall_cycles;
`endif

   localparam logic [5:0] XO = 6'b101010;   // illegal filler: must be ignored outside DECODE

   always #5 clk = ~clk;

   multicycle_control #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .op_code   (op_code),
      .zero      (zero),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .ir_write  (ir_write),
      .pc_write  (pc_write),
      .PCSrc     (PCSrc),
      .RegDst    (RegDst),
      .RegWrite  (RegWrite),
      .ExtSel    (ExtSel),
      .OpSel     (OpSel),
      .BSrc      (BSrc),
      .MemWrite  (MemWrite),
      .WBSrc     (WBSrc),
      .comFormat (comFormat),
      .halted    (halted)
`ifdef MULTICYCLE_PERF_CNT_EN
      ,
      .instr_retired (instr_retired),
      .stall_cycles  (stall_cycles)
`endif
   );

   ctl_t  got;
   ctl_t  exp_q[$];
   string name_q[$];
   ctl_t  mon_exp;
   string mon_name;
   int    checks = 0;
   int    errors = 0;

   assign got = {mem_req, ir_write, pc_write, PCSrc, RegDst, RegWrite, ExtSel,
                 OpSel, BSrc, MemWrite, WBSrc, comFormat, halted};

   function automatic ctl_t ctl(input int mr, input int iw, input int pw, input int ps,
                                input int rd, input int rw, input int es, input int os,
                                input int bs, input int mw, input int wb, input int cf,
                                input int h);
      ctl_t c;
      c.mem_req    = 1'(mr);
      c.ir_write   = 1'(iw);
      c.pc_write   = 1'(pw);
      c.pc_src     = 2'(ps);
      c.reg_dst    = 2'(rd);
      c.reg_write  = 1'(rw);
      c.ext_sel    = 1'(es);
      c.op_sel     = 4'(os);
      c.b_src      = 1'(bs);
      c.mem_write  = 1'(mw);
      c.wb_src     = 2'(wb);
      c.com_format = 2'(cf);
      c.halted     = 1'(h);
      return c;
   endfunction

   // Hand-derived control words, fields in order:
   // mem_req ir_write pc_write PCSrc RegDst RegWrite ExtSel OpSel BSrc MemWrite WBSrc comFormat halted
   ctl_t fw, fok, idle, hlt, r_ex, r_wb, ls_ex, sw_m, lw_wb, beq_t, beq_n, jal_ex, j_ex, ori_ex, i_wb;

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_exp  = exp_q.pop_front();
         mon_name = name_q.pop_front();
         checks++;
         if (got !== mon_exp) begin
            errors++;
            $display("FAIL %s at %0t: got %05h required %05h", mon_name, $time, got, mon_exp);
         end
      end
   end

   task automatic cyc(input string n, input logic rdy, input logic z, input logic [5:0] op,
                      input ctl_t e);
      mem_ready = rdy;
      zero      = z;
      op_code   = op;
      exp_q.push_back(e);
      name_q.push_back(n);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      fw     = ctl(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      fok    = ctl(1, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      idle   = ctl(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      hlt    = ctl(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
      r_ex   = ctl(0, 0, 0, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0);
      r_wb   = ctl(0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0);
      ls_ex  = ctl(0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 1, 0);
      sw_m   = ctl(1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
      lw_wb  = ctl(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 0);
      beq_t  = ctl(0, 0, 1, 1, 0, 0, 1, 1,  0, 0, 0, 1, 0);
      beq_n  = ctl(0, 0, 0, 1, 0, 0, 1, 1,  0, 0, 0, 1, 0);
      jal_ex = ctl(0, 0, 1, 2, 2, 1, 0, 0,  0, 0, 2, 2, 0);
      j_ex   = ctl(0, 0, 1, 2, 0, 0, 0, 0,  0, 0, 0, 2, 0);
      ori_ex = ctl(0, 0, 0, 0, 0, 0, 0, 3,  1, 0, 0, 1, 0);
      i_wb   = ctl(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0);

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state, then R-type: F D E W and back to FETCH on cycle 5
      cyc("reset_fetch_wait", 0, 0, XO, fw);
      cyc("r_fetch",  1, 0, XO,   fok);
      cyc("r_decode", 1, 0, OP_R, idle);
      cyc("r_exec",   1, 0, XO,   r_ex);
      cyc("r_wb",     1, 0, XO,   r_wb);
      cyc("lw_fetch", 1, 0, XO,   fok);

      // LW with three MEM wait cycles: 8 cycles total
      cyc("lw_decode", 1, 0, OP_LW, idle);
      cyc("lw_exec",   1, 0, XO,    ls_ex);
      for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 0, 0, XO, fw);
      cyc("lw_mem_done", 1, 0, XO, fw);
      cyc("lw_wb",       1, 0, XO, lw_wb);

      // BEQ taken / not taken
      cyc("beq1_fetch",  1, 0, XO,     fok);
      cyc("beq1_decode", 1, 0, OP_BEQ, idle);
      cyc("beq1_exec",   1, 1, XO,     beq_t);
      cyc("beq2_fetch",  1, 0, XO,     fok);
      cyc("beq2_decode", 1, 0, OP_BEQ, idle);
      cyc("beq2_exec",   1, 0, XO,     beq_n);

      // JAL and J
      cyc("jal_fetch",  1, 0, XO,     fok);
      cyc("jal_decode", 1, 0, OP_JAL, idle);
      cyc("jal_exec",   1, 0, XO,     jal_ex);
      cyc("j_fetch",    1, 0, XO,     fok);
      cyc("j_decode",   1, 0, OP_J,   idle);
      cyc("j_exec",     1, 0, XO,     j_ex);

      // ADDI and ORI (ORI zero-extends)
      cyc("addi_fetch",  1, 0, XO,      fok);
      cyc("addi_decode", 1, 0, OP_ADDI, idle);
      cyc("addi_exec",   1, 0, XO,      ls_ex);
      cyc("addi_wb",     1, 0, XO,      i_wb);
      cyc("ori_fetch",   1, 0, XO,      fok);
      cyc("ori_decode",  1, 0, OP_ORI,  idle);
      cyc("ori_exec",    1, 0, XO,      ori_ex);
      cyc("ori_wb",      1, 0, XO,      i_wb);

      // SW with ready: 4 cycles
      cyc("sw_fetch",  1, 0, XO,    fok);
      cyc("sw_decode", 1, 0, OP_SW, idle);
      cyc("sw_exec",   1, 0, XO,    ls_ex);
      cyc("sw_mem",    1, 0, XO,    sw_m);

      // SW whose ready arrives exactly as the wait limit is reached: completion wins
      cyc("sw2_fetch",  1, 0, XO,    fok);
      cyc("sw2_decode", 1, 0, OP_SW, idle);
      cyc("sw2_exec",   1, 0, XO,    ls_ex);
      for (int i = 0; i < 4; i++) cyc("sw2_mem_wait", 0, 0, XO, sw_m);
      cyc("sw2_mem_limit_ready", 1, 0, XO, sw_m);

      // LW stuck in MEM: watchdog halts after the limit
      cyc("lw2_fetch",  1, 0, XO,    fok);
      cyc("lw2_decode", 1, 0, OP_LW, idle);
      cyc("lw2_exec",   1, 0, XO,    ls_ex);
      for (int i = 0; i < 5; i++) cyc("lw2_mem_wait", 0, 0, XO, fw);
      cyc("lw2_mem_halt", 1, 0, XO, hlt);
      reset_pulse();

      // Illegal opcode: halted and silent for 20 cycles, then rst recovers
      cyc("ill_fetch",  1, 0, XO,    fok);
      cyc("ill_decode", 1, 0, 6'h3f, idle);
      for (int i = 0; i < 20; i++) cyc("ill_halt", 1, 1, XO, hlt);
      reset_pulse();
      cyc("ill_after_rst", 0, 0, XO, fw);

      // FETCH watchdog: four waits allowed, halt after the fifth stalled cycle
      reset_pulse();
      for (int i = 0; i < 5; i++) cyc("wd_fetch_wait", 0, 0, XO, fw);
      cyc("wd_fetch_halt",  0, 0, XO, hlt);
      cyc("wd_fetch_halt2", 1, 0, XO, hlt);
      reset_pulse();

      // FETCH ready at the limit wins, then reset mid-SW MEM wait
      for (int i = 0; i < 4; i++) cyc("wd_win_wait", 0, 0, XO, fw);
      cyc("wd_win_ready", 1, 0, XO,    fok);
      cyc("sw3_decode",   1, 0, OP_SW, idle);
      cyc("sw3_exec",     1, 0, XO,    ls_ex);
      cyc("sw3_mem_wait", 0, 0, XO,    sw_m);
      cyc("sw3_mem_wait", 0, 0, XO,    sw_m);
      reset_pulse();
      cyc("sw3_after_rst", 0, 0, XO, fw);
      cyc("post_fetch",    1, 0, XO,   fok);
      cyc("post_decode",   1, 0, OP_R, idle);
      cyc("post_exec",     1, 0, XO,   r_ex);
      cyc("post_wb",       1, 0, XO,   r_wb);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
